// File: rtl/param_priority_arbiter_pkg.sv
// rtl/param_priority_arbiter_pkg.sv - shared state and mode encodings for the priority arbiter
package param_priority_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/param_priority_arbiter_rr_pick.sv
// rtl/param_priority_arbiter_rr_pick.sv - combinational downward scan from a start index with wrap
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] start_i,
    output logic [$clog2(N)-1:0] winner_o,
    output logic                 valid_o
);

    localparam int IDX_W = $clog2(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             top_bit;
    int             w;

    // rot[t] = req[(start+1+t) mod N], so the highest set bit of rot is the first hit scanning down from start
    always_comb begin
        dbl     = {req_i, req_i};
        rot     = N'(dbl >> ({1'b0, start_i} + 1'b1));
        top_bit = 0;
        for (int t = 0; t < N; t++) begin
            if (rot[t]) begin
                top_bit = t;
            end
        end
        w = int'(start_i) + 1 + top_bit;
        if (w >= N) begin
            w = w - N;
        end
        winner_o = IDX_W'(w);
        valid_o  = |req_i;
    end

endmodule

// File: rtl/param_priority_arbiter.sv
// rtl/param_priority_arbiter.sv - N-way fixed/round-robin arbiter with registered held grant
module param_priority_arbiter
    import param_priority_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [N-1:0]         req,
    input  logic                 done,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid
);

    localparam int IDX_W = $clog2(N);

    state_e           state_q;
    logic [N-1:0]     gnt_q;
    logic [IDX_W-1:0] idx_q;
    logic             valid_q;
    logic [IDX_W-1:0] ptr_q;

    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [IDX_W-1:0] ptr_d;
    logic [N-1:0]     gnt_d;
    logic             release_c;

    // Fixed priority is a round-robin scan that always starts at the top index
    always_comb begin
        start = IDX_W'(N - 1);
        unique case (mode)
            MODE_FIXED: start = IDX_W'(N - 1);
            MODE_RR:    start = ptr_q;
            default:    start = IDX_W'(N - 1);
        endcase
    end

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .req_i    (req),
        .start_i  (start),
        .winner_o (pick_idx),
        .valid_o  (pick_valid)
    );

    assign ptr_d     = (pick_idx == '0) ? IDX_W'(N - 1) : pick_idx - 1'b1;
    assign gnt_d     = {{(N-1){1'b0}}, 1'b1} << pick_idx;
    assign release_c = done | ~req[idx_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= IDX_W'(N - 1);
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_q <= ST_GRANT;
                        gnt_q   <= gnt_d;
                        idx_q   <= pick_idx;
                        valid_q <= 1'b1;
                        ptr_q   <= ptr_d;
                    end
                end
                ST_GRANT: begin
                    // No same-edge re-grant: releasing always passes through one idle cycle
                    if (release_c) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                        idx_q   <= '0;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    idx_q   <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;

endmodule

// File: tb/tb_param_priority_arbiter.sv
// tb/tb_param_priority_arbiter.sv - scoreboard bench for the arbiter at N=4 and N=8
module tb_param_priority_arbiter;

    typedef struct {
        int         cyc;
        int         dut;
        logic [7:0] g;
        logic [2:0] i;
        logic       v;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       mode;
    logic       done;
    logic [7:0] req8;

    logic [3:0] gnt4;
    logic [1:0] idx4;
    logic       v4;
    logic [7:0] gnt8;
    logic [2:0] idx8;
    logic       v8;

    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];
    exp_t em;

    param_priority_arbiter #(.N(4)) u4 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .req       (req8[3:0]),
        .done      (done),
        .gnt       (gnt4),
        .gnt_idx   (idx4),
        .gnt_valid (v4)
    );

    param_priority_arbiter #(.N(8)) u8 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .req       (req8),
        .done      (done),
        .gnt       (gnt8),
        .gnt_idx   (idx8),
        .gnt_valid (v8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [7:0] ag;
        logic [2:0] ai;
        logic       av;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            em = sb.pop_front();
            if (em.dut == 0) begin
                ag = {4'b0, gnt4};
                ai = {1'b0, idx4};
                av = v4;
            end else begin
                ag = gnt8;
                ai = idx8;
                av = v8;
            end
            checks++;
            if (ag !== em.g || ai !== em.i || av !== em.v) begin
                errors++;
                $display("FAIL %s dut%0d cyc%0d: got gnt=%b idx=%0d valid=%b, want gnt=%b idx=%0d valid=%b",
                         em.name, em.dut, cyc, ag, ai, av, em.g, em.i, em.v);
            end
        end
        if (cyc > 0) begin
            checks++;
            if (v4 !== (|gnt4) || v8 !== (|gnt8) || !$onehot0(gnt4) || !$onehot0(gnt8)) begin
                errors++;
                $display("FAIL invariant cyc%0d: got gnt4=%b v4=%b gnt8=%b v8=%b, want one-hot/zero with valid=|gnt",
                         cyc, gnt4, v4, gnt8, v8);
            end
        end
    end

    task automatic expect_out(input int dut, input logic [7:0] g, input logic [2:0] i, input logic v,
                              input string name);
        exp_t e;
        e.cyc  = cyc + 1;
        e.dut  = dut;
        e.g    = g;
        e.i    = i;
        e.v    = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic drive(input logic r, input logic m, input logic d, input logic [7:0] rq);
        rst  = r;
        mode = m;
        done = d;
        req8 = rq;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        drive(1, 0, 1, 8'h0F); expect_out(0, 8'h00, 0, 0, "rst_a"); tick;
        drive(1, 0, 1, 8'h0F); expect_out(0, 8'h00, 0, 0, "rst_b"); tick;
        drive(0, 0, 1, 8'h0F); expect_out(0, 8'h08, 3, 1, "first_after_rst"); tick;
        drive(0, 0, 0, 8'h00); expect_out(0, 8'h00, 0, 0, "drop_rel"); tick;
        drive(0, 0, 0, 8'h00); expect_out(0, 8'h00, 0, 0, "idle_noreq"); tick;

        drive(0, 0, 0, 8'h06); expect_out(0, 8'h04, 2, 1, "fixed_0110"); tick;
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 8'h06); expect_out(0, 8'h04, 2, 1, "fixed_hold"); tick;
        end
        drive(0, 0, 1, 8'h06); expect_out(0, 8'h00, 0, 0, "fixed_done"); tick;
        drive(0, 0, 0, 8'h06); expect_out(0, 8'h04, 2, 1, "fixed_regrant"); tick;
        drive(0, 0, 0, 8'h00); expect_out(0, 8'h00, 0, 0, "fixed_drop"); tick;

        drive(1, 1, 0, 8'h0F); expect_out(0, 8'h00, 0, 0, "rr_rst"); tick;
        drive(0, 1, 0, 8'h0F); expect_out(0, 8'h08, 3, 1, "rr_3"); tick;
        drive(0, 1, 1, 8'h0F); expect_out(0, 8'h00, 0, 0, "rr_gap"); tick;
        drive(0, 1, 0, 8'h0F); expect_out(0, 8'h04, 2, 1, "rr_2"); tick;
        drive(0, 1, 1, 8'h0F); expect_out(0, 8'h00, 0, 0, "rr_gap"); tick;
        drive(0, 1, 0, 8'h0F); expect_out(0, 8'h02, 1, 1, "rr_1"); tick;
        drive(0, 1, 1, 8'h0F); expect_out(0, 8'h00, 0, 0, "rr_gap"); tick;
        drive(0, 1, 0, 8'h0F); expect_out(0, 8'h01, 0, 1, "rr_0"); tick;
        drive(0, 1, 1, 8'h0F); expect_out(0, 8'h00, 0, 0, "rr_gap"); tick;
        drive(0, 1, 0, 8'h0F); expect_out(0, 8'h08, 3, 1, "rr_wrap3"); tick;
        drive(0, 1, 1, 8'h0F); expect_out(0, 8'h00, 0, 0, "rr_gap"); tick;

        drive(0, 1, 0, 8'h0F); expect_out(0, 8'h04, 2, 1, "sparse_2"); tick;
        drive(0, 1, 1, 8'h05); expect_out(0, 8'h00, 0, 0, "sparse_rel"); tick;
        drive(0, 1, 0, 8'h05); expect_out(0, 8'h01, 0, 1, "sparse_0"); tick;
        drive(0, 1, 1, 8'h05); expect_out(0, 8'h00, 0, 0, "sparse_rel"); tick;
        drive(0, 1, 0, 8'h05); expect_out(0, 8'h04, 2, 1, "sparse_wrap2"); tick;
        drive(0, 1, 1, 8'h05); expect_out(0, 8'h00, 0, 0, "sparse_rel"); tick;

        drive(0, 0, 0, 8'h02); expect_out(0, 8'h02, 1, 1, "own1"); tick;
        drive(0, 1, 0, 8'h02); expect_out(0, 8'h02, 1, 1, "mode_toggle"); tick;
        drive(0, 1, 0, 8'h0A); expect_out(0, 8'h02, 1, 1, "other_req_ign"); tick;
        drive(0, 1, 0, 8'h08); expect_out(0, 8'h00, 0, 0, "req_drop_rel"); tick;
        drive(0, 1, 1, 8'h00); expect_out(0, 8'h00, 0, 0, "done_idle"); tick;
        drive(0, 1, 1, 8'h00); expect_out(0, 8'h00, 0, 0, "done_idle2"); tick;

        drive(1, 0, 0, 8'h00); expect_out(1, 8'h00, 0, 0, "n8_rst"); expect_out(0, 8'h00, 0, 0, "n4_rst"); tick;
        drive(0, 0, 0, 8'h20); expect_out(1, 8'h20, 5, 1, "n8_g5"); expect_out(0, 8'h00, 0, 0, "n4_idle"); tick;
        drive(0, 1, 0, 8'h20); expect_out(1, 8'h20, 5, 1, "n8_hold"); tick;
        drive(0, 1, 0, 8'hFF); expect_out(1, 8'h20, 5, 1, "n8_hold2"); expect_out(0, 8'h08, 3, 1, "n4_g3"); tick;
        drive(1, 1, 0, 8'hFF); expect_out(1, 8'h00, 0, 0, "n8_midrst"); expect_out(0, 8'h00, 0, 0, "n4_midrst"); tick;
        drive(0, 1, 0, 8'hFF); expect_out(1, 8'h80, 7, 1, "n8_rr7"); expect_out(0, 8'h08, 3, 1, "n4_rr3"); tick;
        drive(0, 1, 1, 8'hFF); expect_out(1, 8'h00, 0, 0, "n8_rel"); tick;
        drive(0, 1, 0, 8'hFF); expect_out(1, 8'h40, 6, 1, "n8_rr6"); expect_out(0, 8'h04, 2, 1, "n4_rr2"); tick;
        drive(0, 1, 1, 8'hFF); expect_out(1, 8'h00, 0, 0, "n8_rel2"); tick;

        repeat (3) tick;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
